// File: rtl/reorder_buffer_pkg.sv
// Shared widths, the per-entry payload layout and the reserved no-dependency tag
// for the reorder buffer and its query ports.
package reorder_buffer_pkg;

   localparam int REG_W  = 5;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 32;

   // Tag 0 means "no dependency"; it is never handed out at issue.
   localparam int NO_DEP = 0;

   typedef logic [REG_W-1:0]  reg_idx_t;
   typedef logic [DATA_W-1:0] data_t;
   typedef logic [ADDR_W-1:0] addr_t;

   typedef struct packed {
      reg_idx_t rd;
      data_t    val;
      logic     is_store;
      logic     is_branch;
      logic     pred_taken;
      logic     taken;
      addr_t    target;
      addr_t    pc;
   } rob_entry_t;

endpackage

// File: rtl/reorder_buffer_query.sv
// Operand readiness lookup for one decoder query, including the same-cycle
// bypass from the result bus.
module rob_query_port
   import reorder_buffer_pkg::*;
#(
   parameter int ROB_WIDTH = 4
) (
   input  logic [ROB_WIDTH-1:0] index,
   input  logic                 cdb_valid,
   input  logic [ROB_WIDTH-1:0] cdb_index,
   input  data_t                cdb_val,
   input  logic                 slot_busy,
   input  logic                 slot_ready,
   input  data_t                slot_val,
   output logic                 ready,
   output data_t                val
);

   typedef logic [ROB_WIDTH-1:0] tag_t;

   always_comb begin
      ready = 1'b0;
      val   = '0;
      if (index == tag_t'(NO_DEP)) begin
         ready = 1'b1;
      end else if (cdb_valid && (cdb_index == index)) begin
         ready = 1'b1;
         val   = cdb_val;
      end else if (slot_busy && slot_ready) begin
         ready = 1'b1;
         val   = slot_val;
      end
   end

endmodule

// File: rtl/reorder_buffer.sv
// In-order commit controller: hands out rename tags at issue, collects CDB results
// and retires the oldest ready entry per cycle as a register write, store release or branch check.
module reorder_buffer
   import reorder_buffer_pkg::*;
#(
   parameter int ROB_WIDTH = 4
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   input  logic                 rdy_in,
   input  logic                 issue_valid,
   input  logic [4:0]           issue_rd,
   input  logic                 issue_is_store,
   input  logic                 issue_is_branch,
   input  logic                 issue_pred_taken,
   input  logic [31:0]          issue_pc,
   output logic                 rob_full,
   output logic [ROB_WIDTH-1:0] rob_issue_index,
   input  logic                 cdb_valid,
   input  logic [ROB_WIDTH-1:0] cdb_rob_index,
   input  logic [31:0]          cdb_val,
   input  logic                 cdb_taken,
   input  logic [31:0]          cdb_target,
   input  logic [ROB_WIDTH-1:0] dc_to_rob_q1_index,
   input  logic [ROB_WIDTH-1:0] dc_to_rob_q2_index,
   output logic                 rob_to_dc_q1_ready,
   output logic                 rob_to_dc_q2_ready,
   output logic [31:0]          rob_to_dc_q1_val,
   output logic [31:0]          rob_to_dc_q2_val,
   output logic                 rob_to_reg_commit,
   output logic [ROB_WIDTH-1:0] rob_to_reg_rob_index,
   output logic [4:0]           rob_to_reg_index,
   output logic [31:0]          rob_to_reg_val,
   output logic                 rob_to_lsb_store_commit,
   output logic [ROB_WIDTH-1:0] rob_to_lsb_rob_index,
   output logic                 rob_clr,
   output logic [31:0]          rob_clr_pc
);

   localparam int ROB_SIZE = (1 << ROB_WIDTH) - 1;
   typedef logic [ROB_WIDTH-1:0] tag_t;
   localparam tag_t FIRST_TAG = tag_t'(1);
   localparam tag_t LAST_TAG  = tag_t'(ROB_SIZE);

   // Slot 0 exists only so tags index directly; its busy bit is never set.
   rob_entry_t        entries [ROB_SIZE+1];
   logic [ROB_SIZE:0] busy;
   logic [ROB_SIZE:0] ready;
   tag_t              head, tail, count;

   logic     commit_q, store_q, clr_q;
   tag_t     commit_tag_q, store_tag_q;
   reg_idx_t commit_rd_q;
   data_t    commit_val_q;
   addr_t    clr_pc_q;

   logic do_issue, do_cdb, do_commit, mispredict;

   function automatic tag_t next_tag(input tag_t t);
      return (t == LAST_TAG) ? FIRST_TAG : t + FIRST_TAG;
   endfunction

   // Commit looks only at registered readiness, so a CDB write to the head waits a cycle.
   assign do_commit  = busy[head] && ready[head];
   assign mispredict = entries[head].is_branch && (entries[head].taken != entries[head].pred_taken);
   assign do_issue   = issue_valid && (count != LAST_TAG);
   assign do_cdb     = cdb_valid && busy[cdb_rob_index];

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         head         <= FIRST_TAG;
         tail         <= FIRST_TAG;
         count        <= '0;
         busy         <= '0;
         ready        <= '0;
         commit_q     <= 1'b0;
         store_q      <= 1'b0;
         clr_q        <= 1'b0;
         commit_tag_q <= '0;
         store_tag_q  <= '0;
         commit_rd_q  <= '0;
         commit_val_q <= '0;
         clr_pc_q     <= '0;
      end else if (rdy_in) begin
         commit_q <= 1'b0;
         store_q  <= 1'b0;
         clr_q    <= 1'b0;
         if (clr_q) begin
            // The branch has already retired; everything still queued is wrong-path.
            head  <= FIRST_TAG;
            tail  <= FIRST_TAG;
            count <= '0;
            busy  <= '0;
         end else begin
            if (do_cdb) begin
               ready[cdb_rob_index]          <= 1'b1;
               entries[cdb_rob_index].val    <= cdb_val;
               entries[cdb_rob_index].taken  <= cdb_taken;
               entries[cdb_rob_index].target <= cdb_target;
            end
            if (do_issue) begin
               busy[tail]                <= 1'b1;
               ready[tail]               <= 1'b0;
               entries[tail].rd          <= issue_rd;
               entries[tail].is_store    <= issue_is_store;
               entries[tail].is_branch   <= issue_is_branch;
               entries[tail].pred_taken  <= issue_pred_taken;
               entries[tail].pc          <= issue_pc;
               tail                      <= next_tag(tail);
            end
            if (do_commit) begin
               busy[head]   <= 1'b0;
               head         <= next_tag(head);
               commit_q     <= (entries[head].rd != '0);
               commit_tag_q <= head;
               commit_rd_q  <= entries[head].rd;
               commit_val_q <= entries[head].val;
               store_q      <= entries[head].is_store;
               store_tag_q  <= head;
               if (mispredict) begin
                  clr_q    <= 1'b1;
                  clr_pc_q <= entries[head].target;
               end
            end
            count <= count + tag_t'(do_issue) - tag_t'(do_commit);
         end
      end
   end

   assign rob_full        = (count >= tag_t'(ROB_SIZE - 1));
   assign rob_issue_index = tail;

   // Pulses are held while stalled and only shown once rdy_in returns.
   assign rob_to_reg_commit       = commit_q && rdy_in;
   assign rob_to_reg_rob_index    = commit_tag_q;
   assign rob_to_reg_index        = commit_rd_q;
   assign rob_to_reg_val          = commit_val_q;
   assign rob_to_lsb_store_commit = store_q && rdy_in;
   assign rob_to_lsb_rob_index    = store_tag_q;
   assign rob_clr                 = clr_q && rdy_in;
   assign rob_clr_pc              = clr_pc_q;

   rob_query_port #(.ROB_WIDTH(ROB_WIDTH)) u_query1 (
      .index      (dc_to_rob_q1_index),
      .cdb_valid  (cdb_valid),
      .cdb_index  (cdb_rob_index),
      .cdb_val    (cdb_val),
      .slot_busy  (busy[dc_to_rob_q1_index]),
      .slot_ready (ready[dc_to_rob_q1_index]),
      .slot_val   (entries[dc_to_rob_q1_index].val),
      .ready      (rob_to_dc_q1_ready),
      .val        (rob_to_dc_q1_val)
   );

   rob_query_port #(.ROB_WIDTH(ROB_WIDTH)) u_query2 (
      .index      (dc_to_rob_q2_index),
      .cdb_valid  (cdb_valid),
      .cdb_index  (cdb_rob_index),
      .cdb_val    (cdb_val),
      .slot_busy  (busy[dc_to_rob_q2_index]),
      .slot_ready (ready[dc_to_rob_q2_index]),
      .slot_val   (entries[dc_to_rob_q2_index].val),
      .ready      (rob_to_dc_q2_ready),
      .val        (rob_to_dc_q2_val)
   );

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: a program-order queue model checked every cycle,
// plus hand-computed literal expectations at the interesting points.
module tb_reorder_buffer;

   localparam int W = 4;

   logic          clk_in = 1'b0;
   logic          rst_in, rdy_in;
   logic          issue_valid, issue_is_store, issue_is_branch, issue_pred_taken;
   logic [4:0]    issue_rd;
   logic [31:0]   issue_pc;
   logic          rob_full;
   logic [W-1:0]  rob_issue_index;
   logic          cdb_valid, cdb_taken;
   logic [W-1:0]  cdb_rob_index;
   logic [31:0]   cdb_val, cdb_target;
   logic [W-1:0]  dc_to_rob_q1_index, dc_to_rob_q2_index;
   logic          rob_to_dc_q1_ready, rob_to_dc_q2_ready;
   logic [31:0]   rob_to_dc_q1_val, rob_to_dc_q2_val;
   logic          rob_to_reg_commit, rob_to_lsb_store_commit, rob_clr;
   logic [W-1:0]  rob_to_reg_rob_index, rob_to_lsb_rob_index;
   logic [4:0]    rob_to_reg_index;
   logic [31:0]   rob_to_reg_val, rob_clr_pc;

   int n_tests = 0;
   int n_fail  = 0;
   logic check_en = 1'b0;

   always #5 clk_in = ~clk_in;

   reorder_buffer #(.ROB_WIDTH(W)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
      .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_is_store(issue_is_store),
      .issue_is_branch(issue_is_branch), .issue_pred_taken(issue_pred_taken), .issue_pc(issue_pc),
      .rob_full(rob_full), .rob_issue_index(rob_issue_index),
      .cdb_valid(cdb_valid), .cdb_rob_index(cdb_rob_index), .cdb_val(cdb_val),
      .cdb_taken(cdb_taken), .cdb_target(cdb_target),
      .dc_to_rob_q1_index(dc_to_rob_q1_index), .dc_to_rob_q2_index(dc_to_rob_q2_index),
      .rob_to_dc_q1_ready(rob_to_dc_q1_ready), .rob_to_dc_q2_ready(rob_to_dc_q2_ready),
      .rob_to_dc_q1_val(rob_to_dc_q1_val), .rob_to_dc_q2_val(rob_to_dc_q2_val),
      .rob_to_reg_commit(rob_to_reg_commit), .rob_to_reg_rob_index(rob_to_reg_rob_index),
      .rob_to_reg_index(rob_to_reg_index), .rob_to_reg_val(rob_to_reg_val),
      .rob_to_lsb_store_commit(rob_to_lsb_store_commit), .rob_to_lsb_rob_index(rob_to_lsb_rob_index),
      .rob_clr(rob_clr), .rob_clr_pc(rob_clr_pc)
   );

   // ---------------- model: instructions in program order ----------------
   typedef struct {
      logic [3:0]  tag;
      logic [4:0]  rd;
      logic        st, br, pred, rdy, taken;
      logic [31:0] val, target;
   } ent_t;

   ent_t        rob_q[$];
   int          alloc_n = 0;
   logic        e_commit = 1'b0, e_store = 1'b0, e_clr = 1'b0;
   logic [3:0]  e_tag = '0, e_stag = '0;
   logic [4:0]  e_rd = '0;
   logic [31:0] e_val = '0, e_clr_pc = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step();
      ent_t h;
      int   sz0;
      if (rst_in) begin
         rob_q.delete();
         alloc_n  = 0;
         e_commit = 1'b0; e_store = 1'b0; e_clr = 1'b0; e_clr_pc = '0;
      end else if (rdy_in) begin
         if (e_clr) begin
            rob_q.delete();
            alloc_n  = 0;
            e_commit = 1'b0; e_store = 1'b0; e_clr = 1'b0;
         end else begin
            sz0      = rob_q.size();
            e_commit = 1'b0;
            e_store  = 1'b0;
            if (sz0 > 0 && rob_q[0].rdy) begin
               h        = rob_q.pop_front();
               e_commit = (h.rd != 5'd0);
               e_tag    = h.tag; e_rd = h.rd; e_val = h.val;
               e_store  = h.st;  e_stag = h.tag;
               if (h.br && (h.taken != h.pred)) begin
                  e_clr    = 1'b1;
                  e_clr_pc = h.target;
               end
            end
            if (cdb_valid) begin
               foreach (rob_q[i]) begin
                  if (rob_q[i].tag == cdb_rob_index) begin
                     rob_q[i].rdy    = 1'b1;
                     rob_q[i].val    = cdb_val;
                     rob_q[i].taken  = cdb_taken;
                     rob_q[i].target = cdb_target;
                  end
               end
            end
            if (issue_valid && sz0 < 15) begin
               h.tag = 4'((alloc_n % 15) + 1);
               h.rd = issue_rd; h.st = issue_is_store; h.br = issue_is_branch;
               h.pred = issue_pred_taken; h.rdy = 1'b0; h.taken = 1'b0;
               h.val = '0; h.target = '0;
               rob_q.push_back(h);
               alloc_n++;
            end
         end
      end
   endtask

   task automatic q_model(input logic [3:0] idx, output logic r, output logic [31:0] v);
      r = 1'b0;
      v = '0;
      if (idx == 4'd0) begin
         r = 1'b1;
      end else if (cdb_valid && cdb_rob_index == idx) begin
         r = 1'b1;
         v = cdb_val;
      end else begin
         foreach (rob_q[i]) begin
            if (rob_q[i].tag == idx && rob_q[i].rdy) begin
               r = 1'b1;
               v = rob_q[i].val;
            end
         end
      end
   endtask

   task automatic compare_outputs();
      logic        r;
      logic [31:0] v;
      chk("issue_index", rob_issue_index, (alloc_n % 15) + 1);
      chk("full", rob_full, rob_q.size() >= 14);
      chk("reg_commit", rob_to_reg_commit, e_commit && rdy_in);
      if (e_commit && rdy_in) begin
         chk("reg_rob_index", rob_to_reg_rob_index, e_tag);
         chk("reg_index", rob_to_reg_index, e_rd);
         chk("reg_val", rob_to_reg_val, e_val);
      end
      chk("store_commit", rob_to_lsb_store_commit, e_store && rdy_in);
      if (e_store && rdy_in) chk("store_rob_index", rob_to_lsb_rob_index, e_stag);
      chk("clr", rob_clr, e_clr && rdy_in);
      chk("clr_pc", rob_clr_pc, e_clr_pc);
      q_model(dc_to_rob_q1_index, r, v);
      chk("q1_ready", rob_to_dc_q1_ready, r);
      chk("q1_val", rob_to_dc_q1_val, v);
      q_model(dc_to_rob_q2_index, r, v);
      chk("q2_ready", rob_to_dc_q2_ready, r);
      chk("q2_val", rob_to_dc_q2_val, v);
   endtask

   initial forever begin
      @(posedge clk_in);
      model_step();
   end

   initial forever begin
      @(negedge clk_in);
      if (check_en) compare_outputs();
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
      $fatal(1, "watchdog expired");
   end

   // ---------------- driver tasks ----------------
   task automatic do_reset();
      rst_in = 1'b1;
      repeat (2) begin @(posedge clk_in); #1; end
      rst_in = 1'b0;
   endtask

   task automatic drive_issue(input logic [4:0] rd, input logic st, input logic br,
                              input logic pred, input logic [31:0] pc);
      issue_valid = 1'b1; issue_rd = rd; issue_is_store = st;
      issue_is_branch = br; issue_pred_taken = pred; issue_pc = pc;
      @(posedge clk_in); #1;
      issue_valid = 1'b0; issue_is_store = 1'b0; issue_is_branch = 1'b0; issue_pred_taken = 1'b0;
   endtask

   task automatic drive_cdb(input logic [3:0] tag, input logic [31:0] val,
                            input logic taken, input logic [31:0] target);
      cdb_valid = 1'b1; cdb_rob_index = tag; cdb_val = val;
      cdb_taken = taken; cdb_target = target;
      @(posedge clk_in); #1;
      cdb_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int n = 0;
      while ((rob_q.size() != 0 || e_commit || e_store) && n < 60) begin
         @(posedge clk_in); #1;
         n++;
      end
      chk("drain_timeout", n < 60, 1'b1);
   endtask

   // ---------------- directed stimulus ----------------
   initial begin
      rst_in = 1'b1; rdy_in = 1'b1;
      issue_valid = 1'b0; issue_rd = '0; issue_is_store = 1'b0; issue_is_branch = 1'b0;
      issue_pred_taken = 1'b0; issue_pc = '0;
      cdb_valid = 1'b0; cdb_rob_index = '0; cdb_val = '0; cdb_taken = 1'b0; cdb_target = '0;
      dc_to_rob_q1_index = '0; dc_to_rob_q2_index = '0;
      @(posedge clk_in); #1;
      check_en = 1'b1;
      do_reset();

      // reset state
      @(negedge clk_in);
      chk("lit_reset_index", rob_issue_index, 4'd1);
      chk("lit_reset_full", rob_full, 1'b0);
      chk("lit_reset_commit", rob_to_reg_commit, 1'b0);
      chk("lit_reset_clr", rob_clr, 1'b0);
      chk("lit_reset_clr_pc", rob_clr_pc, 32'h0);

      // basic commit
      drive_issue(5'd5, 1'b0, 1'b0, 1'b0, 32'h1000);
      drive_cdb(4'd1, 32'hDEAD, 1'b0, 32'h0);
      @(negedge clk_in);
      chk("lit_no_same_cycle_commit", rob_to_reg_commit, 1'b0);
      @(posedge clk_in); @(negedge clk_in);
      chk("lit_basic_commit", rob_to_reg_commit, 1'b1);
      chk("lit_basic_rd", rob_to_reg_index, 5'd5);
      chk("lit_basic_tag", rob_to_reg_rob_index, 4'd1);
      chk("lit_basic_val", rob_to_reg_val, 32'hDEAD);

      // out-of-order completion, in-order commit
      do_reset();
      drive_issue(5'd1, 1'b0, 1'b0, 1'b0, 32'h2000);
      drive_issue(5'd2, 1'b0, 1'b0, 1'b0, 32'h2004);
      drive_cdb(4'd2, 32'h22, 1'b0, 32'h0);
      drive_cdb(4'd1, 32'h11, 1'b0, 32'h0);
      @(posedge clk_in); @(negedge clk_in);
      chk("lit_ooo_first_tag", rob_to_reg_rob_index, 4'd1);
      chk("lit_ooo_first_val", rob_to_reg_val, 32'h11);
      @(posedge clk_in); @(negedge clk_in);
      chk("lit_ooo_second_commit", rob_to_reg_commit, 1'b1);
      chk("lit_ooo_second_tag", rob_to_reg_rob_index, 4'd2);
      chk("lit_ooo_second_val", rob_to_reg_val, 32'h22);

      // fill and wrap; tag 3 is a store without writeback
      do_reset();
      for (int i = 0; i < 13; i++)
         drive_issue((i == 2) ? 5'd0 : 5'(i + 1), i == 2, 1'b0, 1'b0, 32'h3000 + 32'(4 * i));
      @(negedge clk_in);
      chk("lit_full_at_13", rob_full, 1'b0);
      drive_issue(5'd14, 1'b0, 1'b0, 1'b0, 32'h3034);
      @(negedge clk_in);
      chk("lit_full_at_14", rob_full, 1'b1);
      chk("lit_index_at_14", rob_issue_index, 4'd15);
      drive_issue(5'd15, 1'b0, 1'b0, 1'b0, 32'h3038);
      @(negedge clk_in);
      chk("lit_index_wraps", rob_issue_index, 4'd1);
      for (int i = 1; i <= 15; i++)
         drive_cdb(4'(i), 32'h1000 + 32'(i), 1'b0, 32'h0);
      wait_drain();
      @(negedge clk_in);
      chk("lit_drained_full", rob_full, 1'b0);
      chk("lit_16th_tag", rob_issue_index, 4'd1);
      drive_issue(5'd9, 1'b0, 1'b0, 1'b0, 32'h303C);
      @(negedge clk_in);
      chk("lit_after_16th", rob_issue_index, 4'd2);

      // mispredict flush
      do_reset();
      drive_issue(5'd0, 1'b0, 1'b1, 1'b0, 32'h40);
      drive_issue(5'd7, 1'b0, 1'b0, 1'b0, 32'h44);
      drive_issue(5'd8, 1'b0, 1'b0, 1'b0, 32'h48);
      drive_cdb(4'd2, 32'h22, 1'b0, 32'h0);
      drive_cdb(4'd3, 32'h33, 1'b0, 32'h0);
      drive_cdb(4'd1, 32'h0, 1'b1, 32'h100);
      @(posedge clk_in); #1;
      issue_valid = 1'b1; issue_rd = 5'd9;
      cdb_valid = 1'b1; cdb_rob_index = 4'd2; cdb_val = 32'h99;
      @(negedge clk_in);
      chk("lit_clr", rob_clr, 1'b1);
      chk("lit_clr_pc", rob_clr_pc, 32'h100);
      @(posedge clk_in); #1;
      issue_valid = 1'b0; cdb_valid = 1'b0;
      dc_to_rob_q1_index = 4'd2; dc_to_rob_q2_index = 4'd3;
      @(negedge clk_in);
      chk("lit_flush_no_commit", rob_to_reg_commit, 1'b0);
      chk("lit_flush_index", rob_issue_index, 4'd1);
      chk("lit_flush_q1_gone", rob_to_dc_q1_ready, 1'b0);
      chk("lit_flush_q2_gone", rob_to_dc_q2_ready, 1'b0);
      chk("lit_flush_clr_pc_held", rob_clr_pc, 32'h100);
      repeat (2) begin @(posedge clk_in); #1; end

      // query bypass
      do_reset();
      for (int i = 1; i <= 3; i++) drive_issue(5'(i), 1'b0, 1'b0, 1'b0, 32'h5000);
      dc_to_rob_q1_index = 4'd3; dc_to_rob_q2_index = 4'd2;
      cdb_valid = 1'b1; cdb_rob_index = 4'd3; cdb_val = 32'd7; cdb_taken = 1'b0; cdb_target = '0;
      @(negedge clk_in);
      chk("lit_bypass_ready", rob_to_dc_q1_ready, 1'b1);
      chk("lit_bypass_val", rob_to_dc_q1_val, 32'd7);
      chk("lit_busy_not_ready", rob_to_dc_q2_ready, 1'b0);
      @(posedge clk_in); #1;
      cdb_valid = 1'b0; dc_to_rob_q2_index = 4'd9;
      @(negedge clk_in);
      chk("lit_stored_ready", rob_to_dc_q1_ready, 1'b1);
      chk("lit_stored_val", rob_to_dc_q1_val, 32'd7);
      chk("lit_empty_slot", rob_to_dc_q2_ready, 1'b0);
      @(posedge clk_in); #1;
      dc_to_rob_q1_index = 4'd0; dc_to_rob_q2_index = 4'd0;
      @(negedge clk_in);
      chk("lit_tag0_ready", rob_to_dc_q1_ready, 1'b1);
      chk("lit_tag0_val", rob_to_dc_q1_val, 32'd0);
      drive_cdb(4'd1, 32'hA1, 1'b0, 32'h0);
      drive_cdb(4'd2, 32'hA2, 1'b0, 32'h0);
      wait_drain();

      // stall: rdy_in low freezes issue and CDB
      do_reset();
      drive_issue(5'd4, 1'b0, 1'b0, 1'b0, 32'h6000);
      rdy_in = 1'b0;
      issue_valid = 1'b1; issue_rd = 5'd6;
      cdb_valid = 1'b1; cdb_rob_index = 4'd1; cdb_val = 32'h55;
      @(posedge clk_in); #1;
      rdy_in = 1'b1; issue_valid = 1'b0; cdb_valid = 1'b0;
      @(negedge clk_in);
      chk("lit_stall_index", rob_issue_index, 4'd2);
      @(posedge clk_in); @(negedge clk_in);
      chk("lit_stall_no_commit", rob_to_reg_commit, 1'b0);
      #1;
      drive_cdb(4'd1, 32'h55, 1'b0, 32'h0);
      @(posedge clk_in); @(negedge clk_in);
      chk("lit_after_stall_commit", rob_to_reg_commit, 1'b1);
      chk("lit_after_stall_val", rob_to_reg_val, 32'h55);
      chk("lit_after_stall_rd", rob_to_reg_index, 5'd4);

      // reset with entries pending
      #1;
      drive_issue(5'd3, 1'b0, 1'b0, 1'b0, 32'h7000);
      drive_issue(5'd4, 1'b0, 1'b0, 1'b0, 32'h7004);
      do_reset();
      @(negedge clk_in);
      chk("lit_midreset_index", rob_issue_index, 4'd1);
      chk("lit_midreset_full", rob_full, 1'b0);

      repeat (2) @(posedge clk_in);
      @(negedge clk_in);
      check_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
